// File: rtl/half_alu_pkg.sv
// Shared opcode encoding for the 1-bit ALU slice.
package half_alu_pkg;

   typedef enum logic [2:0] {
      OP_AND    = 3'b000,
      OP_OR     = 3'b001,
      OP_XOR    = 3'b010,
      OP_PASS_A = 3'b011,
      OP_NAND   = 3'b100,
      OP_NOR    = 3'b101,
      OP_XNOR   = 3'b110,
      OP_ADD    = 3'b111
   } op_e;

endpackage

// File: rtl/half_alu_logic.sv
// Combinational opcode decode for one ALU bit: result plus half-adder carry.
module half_alu_logic
   import half_alu_pkg::*;
(
   input  logic a,
   input  logic b,
   input  op_e  op,
   output logic res,
   output logic cy
);

   always_comb begin
      res = 1'b0;
      cy  = 1'b0;
      case (op)
         OP_AND:    res = a & b;
         OP_OR:     res = a | b;
         OP_XOR:    res = a ^ b;
         OP_PASS_A: res = a;
         OP_NAND:   res = ~(a & b);
         OP_NOR:    res = ~(a | b);
         OP_XNOR:   res = ~(a ^ b);
         OP_ADD: begin
            res = a ^ b;
            cy  = a & b;
         end
         default: begin
            res = 1'b0;
            cy  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/half_alu_unit.sv
// Registered 1-bit ALU slice: captures result, carry and a valid pulse each accepted cycle.
module half_alu_unit
   import half_alu_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic in_valid,
   input  logic a,
   input  logic b,
   input  logic o1,
   input  logic o2,
   input  logic o3,
   output logic c,
   output logic c_valid,
   output logic carry
);

   op_e  op;
   logic res;
   logic cy;

   logic c_q, c_d;
   logic carry_q, carry_d;
   logic c_valid_q, c_valid_d;

   assign op = op_e'({o1, o2, o3});

   half_alu_logic u_logic (
      .a   (a),
      .b   (b),
      .op  (op),
      .res (res),
      .cy  (cy)
   );

   // Valid semantics: there is no ready; every cycle with in_valid=1 is accepted,
   // and c_valid is high for exactly the cycle after each accepted edge.
   always_comb begin
      c_d       = c_q;
      carry_d   = carry_q;
      c_valid_d = in_valid;
      if (in_valid) begin
         c_d     = res;
         carry_d = cy;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_q       <= 1'b0;
         carry_q   <= 1'b0;
         c_valid_q <= 1'b0;
      end else begin
         c_q       <= c_d;
         carry_q   <= carry_d;
         c_valid_q <= c_valid_d;
      end
   end

   assign c       = c_q;
   assign carry   = carry_q;
   assign c_valid = c_valid_q;

endmodule

// File: tb/tb_half_alu_unit.sv
// Self-checking bench for half_alu_unit: behavioural model plus directed literal checks.
module tb_half_alu_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic a = 1'b0;
   logic b = 1'b0;
   logic o1 = 1'b0;
   logic o2 = 1'b0;
   logic o3 = 1'b0;
   logic c;
   logic c_valid;
   logic carry;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state and scoreboard: entries are {valid, carry, c}
   logic       m_c  = 1'b0;
   logic       m_cy = 1'b0;
   logic       m_v  = 1'b0;
   logic [2:0] exp_q[$];

   half_alu_unit dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .a        (a),
      .b        (b),
      .o1       (o1),
      .o2       (o2),
      .o3       (o3),
      .c        (c),
      .c_valid  (c_valid),
      .carry    (carry)
   );

   // ---------------- clock ----------------
   initial forever #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Returns {carry, result} from the operation's arithmetic meaning.
   function automatic logic [1:0] model_op(input int av, input int bv, input int opv);
      int s;
      int r;
      int k;
      s = av + bv;
      k = 0;
      case (opv)
         0: r = (s == 2) ? 1 : 0;
         1: r = (s >= 1) ? 1 : 0;
         2: r = s % 2;
         3: r = av;
         4: r = (s == 2) ? 0 : 1;
         5: r = (s == 0) ? 1 : 0;
         6: r = (s % 2 == 0) ? 1 : 0;
         default: begin
            r = s % 2;
            k = s / 2;
         end
      endcase
      return {k[0], r[0]};
   endfunction

   initial forever begin
      logic [1:0] mr;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_c  = 1'b0;
         m_cy = 1'b0;
         m_v  = 1'b0;
         exp_q.delete();
      end else begin
         m_v = in_valid;
         if (in_valid) begin
            mr   = model_op(int'(a), int'(b), int'({o1, o2, o3}));
            m_c  = mr[0];
            m_cy = mr[1];
         end
      end
      exp_q.push_back({m_v, m_cy, m_c});
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every low phase against the latest model state.
   initial forever begin
      logic [2:0] e;
      @(negedge clk);
      if (exp_q.size() > 0) begin
         e = exp_q[$];
         exp_q.delete();
         check("model_c", c, e[0]);
         check("model_carry", carry, e[1]);
         check("model_c_valid", c_valid, e[2]);
      end
   end

   // ---------------- driver ----------------
   task automatic drive(input logic v, input logic av, input logic bv, input logic [2:0] op);
      @(negedge clk);
      in_valid = v;
      a = av;
      b = bv;
      {o1, o2, o3} = op;
   endtask

   task automatic expect_out(input string name, input logic ec, input logic ecy, input logic ev);
      @(posedge clk);
      #1;
      check({name, "_c"}, c, ec);
      check({name, "_carry"}, carry, ecy);
      check({name, "_c_valid"}, c_valid, ev);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [4:0] combo;

      // Reset held from time zero
      repeat (3) @(posedge clk);
      #1;
      check("rst_hold_c", c, 1'b0);
      check("rst_hold_carry", carry, 1'b0);
      check("rst_hold_c_valid", c_valid, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (3) expect_out("idle_after_rst", 1'b0, 1'b0, 1'b0);

      // Single operations
      drive(1'b1, 1'b1, 1'b0, 3'b000); expect_out("and_10", 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 3'b010); expect_out("xor_10", 1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b1, 3'b001); expect_out("or_01", 1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 3'b111); expect_out("add_10", 1'b1, 1'b0, 1'b1);

      // ADD carry, then cleared by a non-ADD op
      drive(1'b1, 1'b1, 1'b1, 3'b111); expect_out("add_11", 1'b0, 1'b1, 1'b1);
      drive(1'b1, 1'b1, 1'b1, 3'b000); expect_out("and_11", 1'b1, 1'b0, 1'b1);

      // Hold with in_valid low
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 1'b0, 3'b000);
         expect_out("hold", 1'b1, 1'b0, 1'b0);
      end

      // Asynchronous reset mid-cycle while c=1
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_c", c, 1'b0);
      check("async_rst_carry", carry, 1'b0);
      check("async_rst_c_valid", c_valid, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (2) expect_out("idle_after_rst2", 1'b0, 1'b0, 1'b0);

      // Exhaustive {a,b,op}, back-to-back
      for (int i = 0; i < 32; i++) begin
         combo = 5'(i);
         drive(1'b1, combo[4], combo[3], combo[2:0]);
      end

      // Randomized stream
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      end

      // Reset between two valid ops, carry set beforehand
      drive(1'b1, 1'b1, 1'b1, 3'b111); expect_out("pre_rst_add", 1'b0, 1'b1, 1'b1);
      #2;
      rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      check("midstream_rst_c", c, 1'b0);
      check("midstream_rst_carry", carry, 1'b0);
      check("midstream_rst_c_valid", c_valid, 1'b0);
      @(negedge clk);
      in_valid = 1'b1;
      a = 1'b1;
      b = 1'b0;
      {o1, o2, o3} = 3'b010;
      #2 rst_n = 1'b1;
      expect_out("first_after_rst", 1'b1, 1'b0, 1'b1);

      drive(1'b0, 1'b0, 1'b0, 3'b000);
      expect_out("final_idle", 1'b1, 1'b0, 1'b0);
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
